// File: rtl/st_adapter_pkg.sv
// Shared types and helpers for the Avalon-ST width adapters.
package st_adapter_pkg;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } symbol_order_t;

    // Width of a field able to hold 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/st_symbol_shift_buffer.sv
// Holds one wide beat and shifts it out a symbol at a time in the chosen order.
module st_symbol_shift_buffer
    import st_adapter_pkg::*;
#(
    parameter int            DATA_WIDTH   = 32,
    parameter int            SYMBOL_WIDTH = 8,
    parameter int            CNT_WIDTH    = 3,
    parameter symbol_order_t ORDER        = LSB_FIRST
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    consume,
    input  logic [DATA_WIDTH-1:0]   load_data,
    input  logic [CNT_WIDTH-1:0]    load_count,
    input  logic                    load_first,
    output logic [SYMBOL_WIDTH-1:0] symbol,
    output logic [CNT_WIDTH-1:0]    remaining,
    output logic                    first
);

    logic [DATA_WIDTH-1:0] buffer_r;
    logic [CNT_WIDTH-1:0]  remaining_r;
    logic                  first_r;

    // Buffer, symbol count and first-symbol flag; a load beats a simultaneous consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            buffer_r    <= {DATA_WIDTH{1'b0}};
            remaining_r <= {CNT_WIDTH{1'b0}};
            first_r     <= 1'b0;
        end else if (load) begin
            buffer_r    <= load_data;
            remaining_r <= load_count;
            first_r     <= load_first;
        end else if (consume) begin
            if (ORDER == LSB_FIRST) begin
                buffer_r <= buffer_r >> SYMBOL_WIDTH;
            end else begin
                buffer_r <= buffer_r << SYMBOL_WIDTH;
            end
            remaining_r <= remaining_r - CNT_WIDTH'(1'b1);
            first_r     <= 1'b0;
        end else begin
            buffer_r    <= buffer_r;
            remaining_r <= remaining_r;
            first_r     <= first_r;
        end
    end

    if (ORDER == LSB_FIRST) begin : g_lsb
        assign symbol = buffer_r[SYMBOL_WIDTH-1:0];
    end else begin : g_msb
        assign symbol = buffer_r[DATA_WIDTH-1 -: SYMBOL_WIDTH];
    end

    assign remaining = remaining_r;
    assign first     = first_r;

endmodule

// File: rtl/st_width_narrowing_adapter_v2_chk.sv
// Protocol checks for the width narrower, kept apart from the datapath.
module st_width_narrowing_adapter_v2_chk #(
    parameter int SYMBOLS     = 4,
    parameter int EMPTY_WIDTH = 2
) (
    input logic                   clk,
    input logic                   reset,
    input logic                   load,
    input logic                   eop,
    input logic [EMPTY_WIDTH-1:0] empty
);

    // An eop beat must leave at least one symbol to emit.
    a_empty_in_range: assert property (@(posedge clk) disable iff (reset)
        !(load && eop && (32'(empty) >= 32'(SYMBOLS))));

endmodule

// File: rtl/st_width_narrowing_adapter_v2.sv
// Avalon-ST width narrower: one wide sink beat becomes SYMBOLS narrow source symbols.
module st_width_narrowing_adapter_v2
    import st_adapter_pkg::*;
#(
    parameter int            ST_SINK_WIDTH   = 32,
    parameter int            ST_SOURCE_WIDTH = 8,
    parameter symbol_order_t SYMBOL_ORDER    = LSB_FIRST,
    parameter int            CHANNEL_WIDTH   = 1,
    localparam int           SYMBOLS         = ST_SINK_WIDTH / ST_SOURCE_WIDTH,
    localparam int           EMPTY_WIDTH     = clog2_min1(SYMBOLS),
    localparam int           CNT_WIDTH       = $clog2(SYMBOLS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       st_sink_ready,
    input  logic                       st_sink_valid,
    input  logic [ST_SINK_WIDTH-1:0]   st_sink_data,
    input  logic                       st_sink_startofpacket,
    input  logic                       st_sink_endofpacket,
    input  logic [EMPTY_WIDTH-1:0]     st_sink_empty,
    input  logic [CHANNEL_WIDTH-1:0]   st_sink_channel,
    input  logic                       st_source_ready,
    output logic                       st_source_valid,
    output logic [ST_SOURCE_WIDTH-1:0] st_source_data,
    output logic                       st_source_startofpacket,
    output logic                       st_source_endofpacket,
    output logic [CHANNEL_WIDTH-1:0]   st_source_channel,
    output logic [CNT_WIDTH-1:0]       symbols_pending
);

    if (((ST_SINK_WIDTH % ST_SOURCE_WIDTH) != 0) || (SYMBOLS < 2)) begin : g_bad_widths
        $fatal(1, "ST_SINK_WIDTH must be a multiple (>1) of ST_SOURCE_WIDTH");
    end

    logic [CNT_WIDTH-1:0]       remaining_s;
    logic                       first_s;
    logic [ST_SOURCE_WIDTH-1:0] symbol_s;
    logic                       consume_s;
    logic                       sink_ready_s;
    logic                       load_s;
    logic [EMPTY_WIDTH-1:0]     empty_clamped_s;
    logic [CNT_WIDTH-1:0]       load_count_s;
    logic                       eop_r;
    logic [CHANNEL_WIDTH-1:0]   channel_r;

    // Handshake and beat sizing; ready is open whenever the last symbol leaves this cycle.
    always_comb begin
        consume_s    = (remaining_s != {CNT_WIDTH{1'b0}}) && st_source_ready;
        sink_ready_s = (remaining_s == {CNT_WIDTH{1'b0}}) ||
                       ((remaining_s == CNT_WIDTH'(1'b1)) && st_source_ready);
        load_s       = st_sink_valid && sink_ready_s;
        if (32'(st_sink_empty) >= 32'(SYMBOLS)) begin
            empty_clamped_s = EMPTY_WIDTH'(SYMBOLS - 1);
        end else begin
            empty_clamped_s = st_sink_empty;
        end
        if (st_sink_endofpacket) begin
            load_count_s = CNT_WIDTH'(SYMBOLS) - CNT_WIDTH'(empty_clamped_s);
        end else begin
            load_count_s = CNT_WIDTH'(SYMBOLS);
        end
    end

    // Sideband captured with each beat and held until the next load.
    always_ff @(posedge clk) begin
        if (reset) begin
            eop_r     <= 1'b0;
            channel_r <= {CHANNEL_WIDTH{1'b0}};
        end else if (load_s) begin
            eop_r     <= st_sink_endofpacket;
            channel_r <= st_sink_channel;
        end else begin
            eop_r     <= eop_r;
            channel_r <= channel_r;
        end
    end

    st_symbol_shift_buffer #(
        .DATA_WIDTH   (ST_SINK_WIDTH),
        .SYMBOL_WIDTH (ST_SOURCE_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH),
        .ORDER        (SYMBOL_ORDER)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .consume    (consume_s),
        .load_data  (st_sink_data),
        .load_count (load_count_s),
        .load_first (st_sink_startofpacket),
        .symbol     (symbol_s),
        .remaining  (remaining_s),
        .first      (first_s)
    );

    st_width_narrowing_adapter_v2_chk #(
        .SYMBOLS     (SYMBOLS),
        .EMPTY_WIDTH (EMPTY_WIDTH)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .eop   (st_sink_endofpacket),
        .empty (st_sink_empty)
    );

    assign st_sink_ready           = sink_ready_s;
    assign st_source_valid         = (remaining_s != {CNT_WIDTH{1'b0}});
    assign st_source_data          = symbol_s;
    assign st_source_startofpacket = first_s && st_source_valid;
    assign st_source_endofpacket   = eop_r && (remaining_s == CNT_WIDTH'(1'b1));
    assign st_source_channel       = channel_r;
    assign symbols_pending         = remaining_s;

endmodule
